// File: rtl/prbs_pkg.sv
// Shared constants and types for the PRBS31 receive checker.
// Polynomial x^31 + x^28 + 1: predicted bit is s[30] ^ s[27], newest bit in s[0].
package prbs_pkg;

    localparam int PRBS31_LEN   = 31;
    localparam int PRBS31_TAP_A = 30;
    localparam int PRBS31_TAP_B = 27;

    localparam int TOTAL_W = 32;
    localparam int LOSS_W  = 16;
    localparam int MATCH_W = 16;
    localparam int FILL_W  = 5;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } lock_state_e;

    function automatic logic prbs31_predict(input logic [PRBS31_LEN-1:0] s);
        return s[PRBS31_TAP_A] ^ s[PRBS31_TAP_B];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter
    import prbs_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_count;

    // Count register: clear wins, then increment unless already saturated.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/prbs31_lock_checker.sv
// Self-synchronizing PRBS31 checker: FILL -> SYNC -> LOCKED with a flywheel predictor
// while locked and windowed error monitoring that drops lock on bursts or bit slips.
module prbs31_lock_checker
    import prbs_pkg::*;
#(
    parameter int LOCK_COUNT  = 64,
    parameter int WINDOW      = 1024,
    parameter int LOSS_THRESH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               data_in,
    input  logic               data_in_valid,
    output logic               locked,
    output logic               error_pulse,
    output logic [TOTAL_W-1:0] total_bits,
    output logic [TOTAL_W-1:0] total_bit_errors,
    output logic [LOSS_W-1:0]  lock_loss_count
);

    localparam int WBITS_W = $clog2(WINDOW);
    localparam int WERRS_W = WBITS_W + 1;

    localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(PRBS31_LEN - 1);
    localparam logic [MATCH_W-1:0] LOCK_TGT   = MATCH_W'(LOCK_COUNT);
    localparam logic [WBITS_W-1:0] WBITS_LAST = WBITS_W'(WINDOW - 1);
    localparam logic [WERRS_W-1:0] LOSS_TGT   = WERRS_W'(LOSS_THRESH);

    lock_state_e             r_state;
    logic [PRBS31_LEN-1:0]   r_s;
    logic [FILL_W-1:0]       r_fill_cnt;
    logic [MATCH_W-1:0]      r_match_cnt;
    logic [WBITS_W-1:0]      r_win_bits;
    logic [WERRS_W-1:0]      r_win_errs;
    logic                    r_locked;
    logic                    r_error_pulse;

    lock_state_e             w_state_nxt;
    logic [PRBS31_LEN-1:0]   w_s_nxt;
    logic [FILL_W-1:0]       w_fill_nxt;
    logic [MATCH_W-1:0]      w_match_nxt;
    logic [WBITS_W-1:0]      w_win_bits_nxt;
    logic [WERRS_W-1:0]      w_win_errs_nxt;
    logic                    w_pulse_nxt;
    logic                    w_inc_bits;
    logic                    w_inc_errs;
    logic                    w_inc_loss;

    logic                    w_pred;
    logic                    w_mismatch;
    logic [MATCH_W-1:0]      w_match_inc;
    logic [WERRS_W-1:0]      w_win_errs_inc;

    assign w_pred         = prbs31_predict(r_s);
    assign w_mismatch     = data_in ^ w_pred;
    assign w_match_inc    = r_match_cnt + MATCH_W'(1);
    assign w_win_errs_inc = r_win_errs + WERRS_W'(1);

    // Next-state logic for the lock FSM, predictor register and window counters.
    always_comb begin
        w_state_nxt    = r_state;
        w_s_nxt        = r_s;
        w_fill_nxt     = r_fill_cnt;
        w_match_nxt    = r_match_cnt;
        w_win_bits_nxt = r_win_bits;
        w_win_errs_nxt = r_win_errs;
        w_pulse_nxt    = 1'b0;
        w_inc_bits     = 1'b0;
        w_inc_errs     = 1'b0;
        w_inc_loss     = 1'b0;
        if (data_in_valid) begin
            case (r_state)
                FILL: begin
                    w_s_nxt = {r_s[PRBS31_LEN-2:0], data_in};
                    if (r_fill_cnt == FILL_LAST) begin
                        w_state_nxt = SYNC;
                        w_fill_nxt  = '0;
                        w_match_nxt = '0;
                    end else begin
                        w_fill_nxt = r_fill_cnt + FILL_W'(1);
                    end
                end
                SYNC: begin
                    w_s_nxt = {r_s[PRBS31_LEN-2:0], data_in};
                    // An all-zero register predicts zeros forever; never let it build lock.
                    if (!w_mismatch && (r_s != '0)) begin
                        if (w_match_inc == LOCK_TGT) begin
                            w_state_nxt    = LOCKED;
                            w_match_nxt    = '0;
                            w_win_bits_nxt = '0;
                            w_win_errs_nxt = '0;
                        end else begin
                            w_match_nxt = w_match_inc;
                        end
                    end else begin
                        w_match_nxt = '0;
                    end
                end
                LOCKED: begin
                    w_s_nxt     = {r_s[PRBS31_LEN-2:0], w_pred};
                    w_inc_bits  = 1'b1;
                    w_inc_errs  = w_mismatch;
                    w_pulse_nxt = w_mismatch;
                    if (w_mismatch && (w_win_errs_inc == LOSS_TGT)) begin
                        w_state_nxt    = FILL;
                        w_fill_nxt     = '0;
                        w_inc_loss     = 1'b1;
                        w_win_bits_nxt = '0;
                        w_win_errs_nxt = '0;
                    end else if (r_win_bits == WBITS_LAST) begin
                        w_win_bits_nxt = '0;
                        w_win_errs_nxt = '0;
                    end else begin
                        w_win_bits_nxt = r_win_bits + WBITS_W'(1);
                        w_win_errs_nxt = w_mismatch ? w_win_errs_inc : r_win_errs;
                    end
                end
                default: begin
                    w_state_nxt = FILL;
                    w_fill_nxt  = '0;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= FILL;
            r_s           <= '0;
            r_fill_cnt    <= '0;
            r_match_cnt   <= '0;
            r_win_bits    <= '0;
            r_win_errs    <= '0;
            r_locked      <= 1'b0;
            r_error_pulse <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_s           <= w_s_nxt;
            r_fill_cnt    <= w_fill_nxt;
            r_match_cnt   <= w_match_nxt;
            r_win_bits    <= w_win_bits_nxt;
            r_win_errs    <= w_win_errs_nxt;
            r_locked      <= (w_state_nxt == LOCKED);
            r_error_pulse <= w_pulse_nxt;
        end
    end

    sat_counter #(.W(TOTAL_W)) u_total_bits (
        .i_clk   (clk),
        .i_clr   (rst),
        .i_inc   (w_inc_bits),
        .o_count (total_bits)
    );

    sat_counter #(.W(TOTAL_W)) u_total_bit_errors (
        .i_clk   (clk),
        .i_clr   (rst),
        .i_inc   (w_inc_errs),
        .o_count (total_bit_errors)
    );

    sat_counter #(.W(LOSS_W)) u_lock_loss_count (
        .i_clk   (clk),
        .i_clr   (rst),
        .i_inc   (w_inc_loss),
        .o_count (lock_loss_count)
    );

    assign locked      = r_locked;
    assign error_pulse = r_error_pulse;

endmodule
